bus_slave_port: RTL and testbench

BUS_SLAVE_PORT -- requirements
Module: bus_slave_port

---
 rtl/bus_slave_port.sv | 179 +++++++++++++++++
 tb/tb_bus_slave_port.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_port.sv
// Serial bus slave with a local word memory.
// Frames are RW, LEN and ADDR, then write data, all LSB first; reads stream words back on s_dout.
module bus_slave_port #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic s_sel,
    input  logic m_valid,
    input  logic m_dout,
    output logic s_ready,
    output logic s_valid,
    output logic s_dout,
    output logic s_busy,
    output logic s_done
);

    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ((ADDR_W > LEN_W) ? ADDR_W : LEN_W)
                                                      : ((DATA_W > LEN_W) ? DATA_W : LEN_W);
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE, RX_HDR, RX_ADDR, RX_DATA, WR_MEM, RD_MEM, TX_DATA, DONE
    } state_t;

    state_t             state;
    logic               rw;
    logic [CNT_W-1:0]   cnt;
    logic [LEN_W-1:0]   words_left;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               xfer;
    logic               abort;
    logic               mem_we;
    logic [DATA_W-1:0]  data_shift;
    logic [ADDR_W-1:0]  addr_shift;
    logic [LEN_W-1:0]   len_shift;
    logic [DATA_W-1:0]  tx_next;

    assign xfer   = s_sel & m_valid & s_ready;
    assign abort  = ~s_sel & (state != IDLE) & (state != DONE);
    assign mem_we = rst & s_sel & (state == WR_MEM);

    // LSB-first fields: each new bit enters at the top and walks down to bit 0.
    assign data_shift = DATA_W'({m_dout, shreg} >> 1);
    assign addr_shift = ADDR_W'({m_dout, addr} >> 1);
    assign len_shift  = LEN_W'({m_dout, words_left} >> 1);
    assign tx_next    = shreg >> 1;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr] <= shreg;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state      <= IDLE;
            rw         <= 1'b0;
            cnt        <= '0;
            words_left <= '0;
            addr       <= '0;
            shreg      <= '0;
            s_ready    <= 1'b1;
            s_valid    <= 1'b0;
            s_dout     <= 1'b0;
            s_busy     <= 1'b0;
            s_done     <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            s_ready <= 1'b1;
            s_valid <= 1'b0;
            s_dout  <= 1'b0;
            s_busy  <= 1'b0;
            s_done  <= 1'b0;
        end else begin
            s_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        rw     <= m_dout;
                        cnt    <= '0;
                        s_busy <= 1'b1;
                        state  <= RX_HDR;
                    end
                end
                RX_HDR: begin
                    if (xfer) begin
                        words_left <= len_shift;
                        if (cnt == CNT_W'(LEN_W - 1)) begin
                            cnt   <= '0;
                            state <= RX_ADDR;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                RX_ADDR: begin
                    if (xfer) begin
                        addr <= addr_shift;
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            cnt <= '0;
                            if (rw) begin
                                s_ready <= 1'b0;
                                state   <= RD_MEM;
                            end else begin
                                state <= RX_DATA;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (xfer) begin
                        shreg <= data_shift;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            cnt     <= '0;
                            s_ready <= 1'b0;
                            state   <= WR_MEM;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                WR_MEM: begin
                    addr <= addr + ADDR_W'(1);
                    if (words_left == '0) begin
                        s_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        words_left <= words_left - LEN_W'(1);
                        s_ready    <= 1'b1;
                        state      <= RX_DATA;
                    end
                end
                RD_MEM: begin
                    shreg   <= mem[addr];
                    s_dout  <= mem[addr][0];
                    s_valid <= 1'b1;
                    cnt     <= '0;
                    state   <= TX_DATA;
                end
                TX_DATA: begin
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        // Last bit of the word is on s_dout now; one idle cycle follows.
                        cnt     <= '0;
                        addr    <= addr + ADDR_W'(1);
                        s_valid <= 1'b0;
                        s_dout  <= 1'b0;
                        if (words_left == '0) begin
                            s_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            words_left <= words_left - LEN_W'(1);
                            state      <= RD_MEM;
                        end
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        shreg  <= tx_next;
                        s_dout <= tx_next[0];
                    end
                end
                DONE: begin
                    s_ready <= 1'b1;
                    s_busy  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: writes, bursts with wrap, reads, stalls, abort and reset.
module tb_bus_slave_port;

    logic clock = 1'b0;
    logic rst;
    logic s_sel;
    logic m_valid;
    logic m_dout;
    logic s_ready;
    logic s_valid;
    logic s_dout;
    logic s_busy;
    logic s_done;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int exp_done    = 0;

    logic [7:0] model [4096];
    logic [7:0] wdata [16];

    typedef struct packed {
        logic v;
        logic d;
        logic dn;
    } exp_t;

    exp_t exp_q [$];

    bus_slave_port #(.ADDR_W(12), .DATA_W(8), .LEN_W(4)) dut (
        .clock   (clock),
        .rst     (rst),
        .s_sel   (s_sel),
        .m_valid (m_valid),
        .m_dout  (m_dout),
        .s_ready (s_ready),
        .s_valid (s_valid),
        .s_dout  (s_dout),
        .s_busy  (s_busy),
        .s_done  (s_done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (s_done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        vectors++;
        assert (obs === want)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic send_bit(input logic b, input bit stall);
        int guard = 0;
        if (stall) begin
            m_valid = 1'b0;
            m_dout  = ~b;
            @(negedge clock);
        end
        while (s_ready !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) check("ready_timeout", 16'(s_ready), 16'h1);
        m_valid = 1'b1;
        m_dout  = b;
        @(negedge clock);
    endtask

    task automatic send_bits(input logic [15:0] val, input int n, input bit stall);
        for (int i = 0; i < n; i++) send_bit(val[i], stall);
    endtask

    task automatic do_write(input logic [11:0] a, input int nwords, input bit stall, input int abort_bits);
        send_bit(1'b0, stall);
        send_bits(16'(nwords - 1), 4, stall);
        send_bits(16'(a), 12, stall);
        for (int w = 0; w < nwords; w++) begin
            logic [11:0] idx;
            for (int i = 0; i < 8; i++) begin
                if (w * 8 + i == abort_bits) begin
                    s_sel   = 1'b0;
                    m_valid = 1'b0;
                    @(negedge clock);
                    check("abort_busy", 16'(s_busy), 16'h0);
                    check("abort_ready", 16'(s_ready), 16'h1);
                    check("abort_valid", 16'(s_valid), 16'h0);
                    s_sel = 1'b1;
                    repeat (3) @(negedge clock);
                    return;
                end
                send_bit(wdata[w][i], stall);
            end
            idx = a + 12'(w);
            model[idx] = wdata[w];
        end
        m_valid = 1'b0;
        check("wr_mem_ready", 16'(s_ready), 16'h0);
        check("done_early", 16'(s_done), 16'h0);
        @(negedge clock);
        check("done_pulse", 16'(s_done), 16'h1);
        @(negedge clock);
        check("done_clear", 16'(s_done), 16'h0);
        check("idle_busy", 16'(s_busy), 16'h0);
        check("idle_ready", 16'(s_ready), 16'h1);
        exp_done++;
    endtask

    task automatic do_read(input logic [11:0] a, input int nwords);
        exp_t e;
        send_bit(1'b1, 1'b0);
        send_bits(16'(nwords - 1), 4, 1'b0);
        send_bits(16'(a), 12, 1'b0);
        exp_q.push_back(exp_t'(3'b000));
        for (int w = 0; w < nwords; w++) begin
            logic [11:0] idx;
            logic [7:0]  d;
            idx = a + 12'(w);
            d   = model[idx];
            for (int i = 0; i < 8; i++) begin
                e.v = 1'b1; e.d = d[i]; e.dn = 1'b0;
                exp_q.push_back(e);
            end
            exp_q.push_back((w == nwords - 1) ? exp_t'(3'b001) : exp_t'(3'b000));
        end
        exp_q.push_back(exp_t'(3'b000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_cycle", 16'({s_valid, s_dout, s_done}), 16'(e));
            m_valid = (exp_q.size() > 0) ? 1'b1 : 1'b0;
            m_dout  = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        m_valid = 1'b0;
        check("rd_end_busy", 16'(s_busy), 16'h0);
        exp_done++;
    endtask

    initial begin
        rst     = 1'b0;
        s_sel   = 1'b0;
        m_valid = 1'b0;
        m_dout  = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", 16'(s_ready), 16'h1);
        check("rst_valid", 16'(s_valid), 16'h0);
        check("rst_dout", 16'(s_dout), 16'h0);
        check("rst_busy", 16'(s_busy), 16'h0);
        check("rst_done", 16'(s_done), 16'h0);
        rst   = 1'b1;
        s_sel = 1'b1;
        @(negedge clock);

        wdata[0] = 8'hA5;
        do_write(12'h081, 1, 1'b0, -1);
        do_read(12'h081, 1);

        for (int i = 0; i < 16; i++) wdata[i] = 8'(i);
        do_write(12'hFFE, 16, 1'b0, -1);
        do_read(12'h000, 4);
        do_read(12'hFFE, 3);

        wdata[0] = 8'h3C;
        do_write(12'h010, 1, 1'b1, -1);
        do_read(12'h010, 1);

        wdata[0] = 8'h77;
        do_write(12'h020, 1, 1'b0, -1);
        wdata[0] = 8'h99;
        do_write(12'h020, 1, 1'b0, 4);
        check("abort_no_done", 16'(done_seen), 16'(exp_done));
        do_read(12'h020, 1);

        send_bit(1'b1, 1'b0);
        send_bits(16'h0, 4, 1'b0);
        send_bits(16'h000, 12, 1'b0);
        m_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_rst_valid", 16'(s_valid), 16'h1);
        rst = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        check("mid_rst_valid", 16'(s_valid), 16'h0);
        check("mid_rst_busy", 16'(s_busy), 16'h0);
        check("mid_rst_ready", 16'(s_ready), 16'h1);
        check("mid_rst_dout", 16'(s_dout), 16'h0);
        do_read(12'h001, 1);

        repeat (3) @(negedge clock);
        check("done_count", 16'(done_seen), 16'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
